// File: rtl/pipeline_hazard_controller_if.sv
// Decode-stage bundle between the datapath and the hazard controller.
//
// There is no valid/ready handshake on this bundle. The decode fields are
// sampled every cycle, and useRsD/useRtD/regWriteD act as the qualifiers. The
// controller outputs are combinational responses to those fields in the same
// cycle.
//
// Modport master (datapath side): drives rsD, rtD, useRsD, useRtD, regWriteD,
//                                 mem2RegD, writeRegD, branchD and eq;
//                                 receives fad, fbd, stallF, stallD, flushD,
//                                 flushE and pcSrc.
// Modport slave (controller side): the mirror image of master.
interface pipeline_hazard_controller_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic       useRsD;
  logic       useRtD;
  logic       regWriteD;
  logic       mem2RegD;
  logic [4:0] writeRegD;
  logic       branchD;
  logic       eq;
  logic [1:0] fad;
  logic [1:0] fbd;
  logic       stallF;
  logic       stallD;
  logic       flushD;
  logic       flushE;
  logic       pcSrc;

  modport master (
    output rsD, rtD, useRsD, useRtD, regWriteD, mem2RegD, writeRegD, branchD, eq,
    input  fad, fbd, stallF, stallD, flushD, flushE, pcSrc
  );

  modport slave (
    input  rsD, rtD, useRsD, useRtD, regWriteD, mem2RegD, writeRegD, branchD, eq,
    output fad, fbd, stallF, stallD, flushD, flushE, pcSrc
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for the five-stage datapath.
//
// The controller keeps a shadow scoreboard of the E, M and WB stages. From
// that scoreboard it drives the decode-stage forward selects, inserts load-use
// stalls and resolves branches in decode. It also keeps saturating counters of
// stall cycles and flush cycles.
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   hz          decode bundle (slave modport): D fields in, hazard controls out
//   stallCnt    number of cycles with stallD=1, saturating at all-ones
//   flushCnt    number of cycles with flushD=1, saturating at all-ones
//   dbg_shadow  shadow scoreboard {WB, M, E}. Each stage is 8 bits wide:
//               {vld, regWrite, mem2Reg, writeReg[4:0]}
module pipeline_hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  pipeline_hazard_controller_if.slave  hz,
  output logic [CNT_W-1:0]             stallCnt,
  output logic [CNT_W-1:0]             flushCnt,
  output logic [23:0]                  dbg_shadow
);

  typedef struct packed {
    logic       vld;
    logic       reg_write;
    logic       mem2reg;
    logic [4:0] write_reg;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_t e_q, e_d, m_q, m_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic stall_raw, take_raw, stall, pc_src;
  logic [1:0] fad_raw, fbd_raw;

  // Register 0 is hard-wired, so a write to it never counts as a match.
  function automatic logic stage_writes(input stage_t s, input logic [4:0] r);
    return s.vld & s.reg_write & (s.write_reg == r) & (r != 5'd0);
  endfunction

  // The nearest producer wins. A load that is still in E has no data yet, so
  // its select is a don't-care (0) and the stall logic holds decode back
  // instead. A match in WB also selects 0, because the register file writes
  // before it reads.
  function automatic logic [1:0] fwd_sel(input stage_t e, input stage_t m,
                                         input logic [4:0] r, input logic use_r);
    if (!use_r)                  return 2'd0;
    else if (stage_writes(e, r)) return e.mem2reg ? 2'd0 : 2'd1;
    else if (stage_writes(m, r)) return m.mem2reg ? 2'd2 : 2'd3;
    else                         return 2'd0;
  endfunction

  always_comb begin
    stall_raw = (hz.useRsD & stage_writes(e_q, hz.rsD) & e_q.mem2reg) |
                (hz.useRtD & stage_writes(e_q, hz.rtD) & e_q.mem2reg);
    // When a stall and a taken branch coincide, the stall wins. The branch is
    // re-evaluated next cycle, once the load has moved to M.
    take_raw  = hz.branchD & hz.eq & ~stall_raw;
    fad_raw   = fwd_sel(e_q, m_q, hz.rsD, hz.useRsD);
    fbd_raw   = fwd_sel(e_q, m_q, hz.rtD, hz.useRtD);
    // While reset is held, every control output is forced inactive at once,
    // without waiting for a clock edge.
    stall     = stall_raw & ~rst;
    pc_src    = take_raw & ~rst;
  end

  assign hz.fad    = rst ? 2'd0 : fad_raw;
  assign hz.fbd    = rst ? 2'd0 : fbd_raw;
  assign hz.stallF = stall;
  assign hz.stallD = stall;
  assign hz.flushE = stall;
  assign hz.pcSrc  = pc_src;
  assign hz.flushD = pc_src;

  // E, M and WB never stall, so the shadow pipeline shifts every cycle. A
  // stalled decode enters E as a bubble.
  always_comb begin
    e_d  = stall_raw ? '0 : {1'b1, hz.regWriteD, hz.mem2RegD, hz.writeRegD};
    m_d  = e_q;
    wb_d = m_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (pc_src && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q         <= '0;
      m_q         <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCnt   = stall_cnt_q;
  assign flushCnt   = flush_cnt_q;
  assign dbg_shadow = {wb_q, m_q, e_q};

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Hazard and sequencing controller for the five-stage pipelined datapath (`dataPath`). It keeps a shadow scoreboard of the destination register and write class of each instruction in flight in the E, M and WB stages. From that scoreboard it drives the decode-stage forwarding selects (`fad`/`fbd`), inserts load-use stalls, resolves branches in decode, and maintains saturating stall/flush performance counters.

## Interface
- CNT_W, 16, width of performance counters

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rsD  in  5  decode-stage source register A (instrD[25:21])
- rtD  in  5  decode-stage source register B (instrD[20:16])
- useRsD  in  1  decode instruction reads rs
- useRtD  in  1  decode instruction reads rt
- regWriteD  in  1  decode instruction writes a register
- mem2RegD  in  1  decode instruction is a load
- writeRegD  in  5  resolved destination (regDst ? rd : rt)
- branchD  in  1  decode instruction is a conditional branch (beq)
- eq  in  1  datapath compare of forwarded decode operands
- fad  out  2  rs forward select: 0 regfile, 1 aluOutE, 2 memDataM, 3 aluOutM
- fbd  out  2  rt forward select, same encoding
- stallF  out  1  hold PC
- stallD  out  1  hold F/D register
- flushD  out  1  clear F/D register (taken branch)
- flushE  out  1  load bubble into D/E register (regWriteE=memWriteE=0)
- pcSrc  out  1  take branch target this cycle
- stallCnt  out  CNT_W  cycles with stallD=1, saturating
- flushCnt  out  CNT_W  cycles with flushD=1, saturating

## Operation
- Shadow stages E, M, WB, each holding: `vld`, `regWrite`, `mem2Reg`, `writeReg[4:0]`.
- The shadow pipeline advances every cycle (the datapath has no stall in E/M/WB):
  - WB <= M.
  - M <= E.
  - E <= bubble (vld=0) if stall=1, else the D fields with vld=1.
- A stage "writes r" when vld & regWrite & writeReg==r & r!=0. Register 0 never matches.
- Forward select for source r (independently for rs→fad and rt→fbd), first match wins:
  - E writes r & !E.mem2Reg → 1.
  - E writes r & E.mem2Reg → load-use hazard; select 0 (don't care).
  - M writes r → 2 if M.mem2Reg, else 3.
  - Otherwise 0. A WB-stage match also selects 0: the register file provides write-before-read.
- Select is forced to 0 when the matching use bit is 0.
- stall = (useRsD & hazard on rsD) | (useRtD & hazard on rtD). Hazard = E writes r & E.mem2Reg.
- stallF = stallD = flushE = stall.
- pcSrc = branchD & eq & !stall. flushD = pcSrc. No delay slot; the fetched instruction is killed.
- A stalled branch is re-evaluated the next cycle with the load now in M (fad/fbd=2).
- A stall lasts exactly one cycle per load-use pair. No back-to-back stalls from the same load.
- Counters increment on the clock edge when the corresponding signal is 1. They saturate at all-ones (no wrap).

## Timing
- Forwarding, stall and pcSrc are combinational from the D inputs and shadow state in the same cycle.
- Scoreboard and counters update on the rising clk edge.
- Reset (async, any cycle, including mid-stall or mid-branch):
  - All shadow vld=0; stallCnt=flushCnt=0.
  - While rst=1, all outputs are forced to 0: fad=fbd=0, stallF=stallD=flushD=flushE=pcSrc=0.
- After reset release, the first instruction needs no forwarding until its writer has entered E.
- If stall and a taken-branch condition coincide, stall wins: pcSrc=0, flushD=0.
- If rs==rt and both are used, fad and fbd carry identical values.
- Latency: load→dependent use costs 1 bubble. ALU→dependent use costs 0. A taken branch costs 1 killed fetch.

## Test plan
- ALU chain:
  - Stimulus: `add $3,$1,$2` followed by `sub $4,$3,$5`.
  - Required: cycle 2 fad=1, stall=0.
  - Next instruction using $3: fad=3. Third: fad=0.
- Load-use:
  - Stimulus: `lw $6,0($0)` followed by `add $7,$6,$6`.
  - Required: one cycle of stallF=stallD=flushE=1 with stallCnt=1. Next cycle fad=fbd=2, stall=0.
  - E receives a bubble (shadow E.vld=0).
- Branch:
  - Stimulus: beq with branchD=1, eq=1, no hazard.
  - Required: pcSrc=flushD=1 for one cycle; flushCnt increments to 1.
  - With eq=0: pcSrc=0, flushD=0.
- Branch after load:
  - Stimulus: `lw $2`, then `beq $2,$0`, eq=1.
  - Required: cycle 1 stall=1, pcSrc=0. Cycle 2 fad=2, pcSrc=1.
- $0 and use bits:
  - Stimulus: writer to $0, then a reader of $0 → fad=0, no stall.
  - Stimulus: useRtD=0 with rtD matching a load in E → no stall.
- Reset and saturation:
  - Stimulus: assert rst during a stall cycle.
  - Required: outputs go 0 immediately (async); counters=0; no forwarding after release.
  - Counter saturation: with CNT_W=4, 20 stalls → stallCnt=15.
